// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID register: owns PCF, keeps one imem request
// outstanding, and absorbs decode stalls and execute redirects.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XLEN-1:0] pcf;
  logic [XLEN-1:0] pcf_nxt;
  logic [XLEN-1:0] drop_pc;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] tgt;
  logic [31:0]     hold_word;
  logic [31:0]     word;
  logic            deliver;
  logic            tgt_load;
  logic            hold_load;

  assign pc_inc    = pcf + XLEN'(4);
  assign tgt       = PCTargetE & ~XLEN'(3);
  assign imem_addr = pcf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= REQ;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ: begin
        if (PCSrcE && !imem_rvalid)
          state_nxt = DROP;
        else if (!PCSrcE && imem_rvalid && StallD)
          state_nxt = HOLD;
      end
      DROP: begin
        if (imem_rvalid) state_nxt = REQ;
      end
      HOLD: begin
        if (PCSrcE || !StallD) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // Redirect always beats a same-cycle delivery.
  always_comb begin
    imem_req  = 1'b1;
    deliver   = 1'b0;
    word      = imem_rdata;
    pcf_nxt   = pcf;
    tgt_load  = 1'b0;
    hold_load = 1'b0;
    unique case (state)
      REQ: begin
        if (PCSrcE) begin
          if (imem_rvalid) pcf_nxt = tgt;
          else             tgt_load = 1'b1;
        end else if (imem_rvalid) begin
          if (StallD) begin
            hold_load = 1'b1;
          end else begin
            deliver = 1'b1;
            pcf_nxt = pc_inc;
          end
        end
      end
      DROP: begin
        tgt_load = PCSrcE;
        if (imem_rvalid)
          pcf_nxt = PCSrcE ? tgt : drop_pc;
      end
      HOLD: begin
        imem_req = 1'b0;
        word     = hold_word;
        if (PCSrcE) begin
          pcf_nxt = tgt;
        end else if (!StallD) begin
          deliver = 1'b1;
          pcf_nxt = pc_inc;
        end
      end
      default: begin
        imem_req = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf       <= RESET_PC;
      drop_pc   <= RESET_PC;
      hold_word <= '0;
    end else begin
      pcf <= pcf_nxt;
      if (tgt_load)  drop_pc   <= tgt;
      if (hold_load) hold_word <= imem_rdata;
    end
  end

  // IF/ID: flush beats stall, stall beats delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD <= InstrD;
    end else if (deliver) begin
      InstrD   <= word;
      PCD      <= pcf;
      PCPlus4D <= pc_inc;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: addr-tagged imem model with programmable
// latency, delivered-PC scoreboard, directed stall/redirect/reset cases.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int n_chk;
  int n_fail;
  int lat;
  int waited;
  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory answers after 'lat' waiting cycles of a held request.
  assign imem_rvalid = imem_req && (waited >= lat);
  assign imem_rdata  = tag(imem_addr);

  always @(posedge clk or posedge reset) begin
    if (reset)                         waited <= 0;
    else if (!imem_req || imem_rvalid) waited <= 0;
    else                               waited <= waited + 1;
  end

  task automatic check(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic cyc();
    logic st;
    logic fl;
    logic [31:0] pc;
    @(posedge clk);
    st = StallD;
    fl = FlushD;
    #1;
    if (ValidD && !st && !fl) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(ValidD), 32'd0);
      end else begin
        pc = exp_q.pop_front();
        check("pcd", PCD, pc);
        check("instr", InstrD, tag(pc));
        check("pcplus4", PCPlus4D, pc + 32'd4);
      end
    end
  endtask

  task automatic chk_reset_vals(input string t);
    check({t, "_instr"}, InstrD, 32'h0000_0013);
    check({t, "_valid"}, 32'(ValidD), 32'd0);
    check({t, "_pcd"}, PCD, 32'd0);
    check({t, "_pcp4"}, PCPlus4D, 32'd0);
    check({t, "_req"}, 32'(imem_req), 32'd1);
    check({t, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    lat = 0;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");

    // 1: zero-wait stream
    reset = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cyc();
    check("t1_valid", 32'(ValidD), 32'd1);
    cyc();
    check("t1_addr", imem_addr, 32'h8);

    // 2: word 0x8 arrives under a 3-cycle stall
    StallD = 1'b1;
    repeat (3) begin
      cyc();
      check("t2_req_hold", 32'(imem_req), 32'd0);
      check("t2_pcd_held", PCD, 32'h4);
    end
    StallD = 1'b0;
    exp_q.push_back(32'h8);
    cyc();
    check("t2_next_addr", imem_addr, 32'hC);
    exp_q.push_back(32'hC);
    cyc();
    check("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: redirect while 0x10 waits; second redirect overwrites target
    lat = 2;
    PCSrcE = 1'b1;
    PCTargetE = 32'h0F0;
    cyc();
    check("t3_addr_held", imem_addr, 32'h10);
    check("t3_valid0", 32'(ValidD), 32'd0);
    PCTargetE = 32'h100;
    cyc();
    check("t3_valid1", 32'(ValidD), 32'd0);
    PCSrcE = 1'b0;
    cyc();
    check("t3_new_addr", imem_addr, 32'h100);
    check("t3_valid2", 32'(ValidD), 32'd0);
    exp_q.push_back(32'h100);
    repeat (2) begin
      cyc();
      check("t3_wait_valid", 32'(ValidD), 32'd0);
    end
    cyc();
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: flush+stall together, then redirect coincident with rvalid
    lat = 0;
    StallD = 1'b1;
    FlushD = 1'b1;
    cyc();
    check("t4_instr_nop", InstrD, 32'h0000_0013);
    check("t4_valid", 32'(ValidD), 32'd0);
    StallD = 1'b0;
    FlushD = 1'b0;
    exp_q.push_back(32'h104);
    cyc();
    PCSrcE = 1'b1;
    PCTargetE = 32'h200;
    cyc();
    check("t4_drop_valid", 32'(ValidD), 32'd0);
    check("t4_addr", imem_addr, 32'h200);
    PCSrcE = 1'b0;
    exp_q.push_back(32'h200);
    cyc();
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: PC wrap and target alignment
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    cyc();
    check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    PCSrcE = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    cyc();
    check("t5_wrap_addr", imem_addr, 32'h0);
    PCSrcE = 1'b1;
    PCTargetE = 32'h203;
    cyc();
    check("t5_align_addr", imem_addr, 32'h200);
    PCSrcE = 1'b0;
    exp_q.push_back(32'h200);
    cyc();
    check("t5_drain", 32'(exp_q.size()), 32'd0);

    // 6: reset in the middle of DROP
    lat = 3;
    PCSrcE = 1'b1;
    PCTargetE = 32'h300;
    cyc();
    PCSrcE = 1'b0;
    check("t6_addr_held", imem_addr, 32'h204);
    cyc();
    check("t6_drop_req", 32'(imem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("t6");
    lat = 0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cyc();
    cyc();
    check("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
